// File: rtl/crt_encoder_if.sv
// Handshake bundle for crt_encoder: residue-pair request in, reconstructed word and status out.
interface crt_encoder_if #(
  parameter int WIDTH_W = 13,
  parameter int WIDTH_R = 7
);
  logic               start;
  logic [WIDTH_R-1:0] A;
  logic [WIDTH_R-1:0] B;
  logic [WIDTH_W-1:0] W;
  logic               busy;
  logic               done;
  logic               err;

  modport master (output start, A, B, input W, busy, done, err);
  modport slave  (input start, A, B, output W, busy, done, err);
endinterface

// File: rtl/crt_encoder.sv
// CRT reconstruction of W from (W mod MOD_A, W mod MOD_B) with consecutive moduli, via shift-add.
// Optional input range checking is enabled by defining CRT_RANGE_CHECK_EN.
module crt_encoder #(
  parameter int WIDTH_W = 13,
  parameter int WIDTH_R = 7,
  parameter int MOD_A   = 80,
  parameter int MOD_B   = 81
) (
  input logic         clk,
  input logic         reset,
  crt_encoder_if.slave bus
);
  localparam int CW = $clog2(WIDTH_R + 1);
  localparam logic [WIDTH_R-1:0] MOD_B_R = WIDTH_R'(MOD_B);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REDUCE = 2'd1;
  localparam logic [1:0] MUL    = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  if (MOD_B != MOD_A + 1) begin : g_mod_check
    $error("crt_encoder: MOD_B must equal MOD_A+1");
  end

  logic [1:0]         state;
  logic [WIDTH_R-1:0] a_r, b_r, k_r;
  logic [WIDTH_W:0]   acc, mcand;
  logic [CW-1:0]      cnt;
  logic [WIDTH_W-1:0] w_r;
  logic               busy_r, done_r;

`ifdef CRT_RANGE_CHECK_EN
  localparam logic [WIDTH_R-1:0] MOD_A_R = WIDTH_R'(MOD_A);
  logic bad_r, err_r;
  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.W    = w_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // NOTE: every register here is state, so all updates are non-blocking; mixing in
  // blocking assignments would make results depend on simulator process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      k_r    <= '0;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      w_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef CRT_RANGE_CHECK_EN
      bad_r  <= 1'b0;
      err_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r    <= bus.A;
            b_r    <= bus.B;
            busy_r <= 1'b1;
`ifdef CRT_RANGE_CHECK_EN
            // Out-of-range residues skip the datapath and report on the next edge.
            if (bus.A >= MOD_A_R || bus.B >= MOD_B_R) begin
              bad_r <= 1'b1;
              state <= FINISH;
            end else begin
              bad_r <= 1'b0;
              state <= REDUCE;
            end
`else
            state <= REDUCE;
`endif
          end
        end

        REDUCE: begin
          // k = (A - B) mod MOD_B, since MOD_A is -1 modulo MOD_B.
          k_r   <= (a_r >= b_r) ? a_r - b_r : a_r - b_r + MOD_B_R;
          acc   <= '0;
          mcand <= (WIDTH_W+1)'(MOD_A);
          cnt   <= CW'(WIDTH_R);
          state <= MUL;
        end

        MUL: begin
          if (k_r[0]) acc <= acc + mcand;
          k_r   <= k_r >> 1;
          mcand <= mcand << 1;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FINISH;
        end

        FINISH: begin
          // Stay in FINISH through the done cycle so a start coinciding with done is dropped.
          if (!done_r) begin
`ifdef CRT_RANGE_CHECK_EN
            if (!bad_r) w_r <= WIDTH_W'(acc + (WIDTH_W+1)'(a_r));
            err_r <= bad_r;
`else
            w_r <= WIDTH_W'(acc + (WIDTH_W+1)'(a_r));
`endif
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end else begin
            done_r <= 1'b0;
`ifdef CRT_RANGE_CHECK_EN
            err_r  <= 1'b0;
`endif
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crt_encoder.sv
// Directed self-checking bench for crt_encoder: latency, wrap-around, busy/start rules, async reset, full sweep.
module tb_crt_encoder;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  crt_encoder_if bus ();

  crt_encoder dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request; returns edges from the start-sampling edge to done, busy cycles, W and err at done.
  task automatic run_op(input logic [6:0] a, input logic [6:0] b, output int lat,
                        output int busy_cyc, output logic [12:0] w, output logic err);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_cyc++;
      @(posedge clk);
      #1;
      lat++;
    end
    w   = bus.W;
    err = bus.err;
    @(posedge clk);
    #1;
  endtask

  int          lat, busy_cyc, n_done, done_at0, done_at1;
  logic [12:0] w;
  logic        err;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    reset     = 1'b0;
    #1 reset  = 1'b1;
    #2;
    check("rst_W", bus.W, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    @(negedge clk);
    reset = 1'b0;

    // T1: 40 + 80*12
    run_op(7'd40, 7'd28, lat, busy_cyc, w, err);
    check("t1_latency", lat, 9);
    check("t1_W", w, 1000);
    check("t1_busy_cycles", busy_cyc, 9);
    check("t1_err", err, 0);
    check("t1_busy_after", bus.busy, 0);

    // T2: zero and maximum
    run_op(7'd0, 7'd0, lat, busy_cyc, w, err);
    check("t2_zero_W", w, 0);
    run_op(7'd79, 7'd80, lat, busy_cyc, w, err);
    check("t2_max_W", w, 6479);
    check("t2_max_latency", lat, 9);

    // T3: A<B wraps through +MOD_B
    run_op(7'd0, 7'd1, lat, busy_cyc, w, err);
    check("t3_wrap_W", w, 6400);
    run_op(7'd5, 7'd80, lat, busy_cyc, w, err);
    check("t3_wrap2_W", w, 485);

    // T4: start held for 20 edges; W holds old value mid-computation, results every 11 cycles
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 7'd40;
    bus.B     = 7'd28;
    n_done    = 0;
    done_at0  = -1;
    done_at1  = -1;
    @(posedge clk);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (i == 19) bus.start = 1'b0;
      if (i == 4) check("t4_W_held", bus.W, 485);
      if (bus.done === 1'b1) begin
        if (n_done == 0) done_at0 = i;
        else if (n_done == 1) done_at1 = i;
        n_done++;
        check("t4_W", bus.W, 1000);
      end
    end
    check("t4_done_count", n_done, 2);
    check("t4_first_done", done_at0, 9);
    check("t4_period", done_at1 - done_at0, 11);

    // start pulse during busy with other operands is neither taken nor queued
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 7'd0;
    bus.B     = 7'd1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (lat == 3) begin
        bus.start = 1'b1;
        bus.A     = 7'd5;
        bus.B     = 7'd80;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    check("busy_start_latency", lat, 9);
    check("busy_start_W", bus.W, 6400);
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) n_done++;
    end
    check("busy_start_not_queued", n_done, 0);

    // T5: asynchronous reset in the middle of MUL
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 7'd40;
    bus.B     = 7'd28;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_W", bus.W, 0);
    check("t5_busy", bus.busy, 0);
    check("t5_done", bus.done, 0);
    @(negedge clk);
    reset = 1'b0;
    run_op(7'd40, 7'd28, lat, busy_cyc, w, err);
    check("t5_after_latency", lat, 9);
    check("t5_after_W", w, 1000);

    // T6: out-of-range A
    run_op(7'd80, 7'd3, lat, busy_cyc, w, err);
`ifdef CRT_RANGE_CHECK_EN
    check("t6_latency", lat, 1);
    check("t6_err", err, 1);
    check("t6_W_unchanged", w, 1000);
    check("t6_busy_cycles", busy_cyc, 1);
`else
    check("t6_latency", lat, 9);
    check("t6_err", err, 0);
`endif

    // Scoreboard sweep over the full valid range
    for (int v = 0; v < 6480; v++) begin
      run_op(7'(v % 80), 7'(v % 81), lat, busy_cyc, w, err);
      check("sweep_W", w, v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
